// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card responder (card side of the link).
// Receives 48-bit command frames on MOSI/SCLK/CS (mode 0). Answers each frame
// with NCR_BYTES 0xFF filler bytes, then an R1 byte. Tracks the init state:
// idle flag, CMD55 app prefix and the ACMD41 busy countdown.
//
// Optional build macro: SD_CRC_CHECK_EN. When defined, CRC7 of each frame is
// checked and a mismatch answers R1 = 0x08 | idle.
//
// Ports:
//   CLOCK50  system clock
//   RESET    asynchronous active-low reset
//   SCLK     SPI clock from host (mode 0, <= CLOCK50/8)
//   MOSI     host-to-card data
//   CS       chip select, active low
//   MISO     card-to-host data, idles high
//   CMD_STB  one-cycle pulse per accepted command frame
//   CMD_IDX  index of the last accepted command
//   CMD_ARG  argument of the last accepted command
//   CMD_APP  last accepted command was prefixed by CMD55
//   IN_IDLE  card idle-state flag (R1 bit 0)
module sd_spi_responder #(
    parameter int unsigned NCR_BYTES       = 1,
    parameter int unsigned ACMD41_BUSY_CNT = 2,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        CMD_STB,
    output logic [5:0]  CMD_IDX,
    output logic [31:0] CMD_ARG,
    output logic        CMD_APP,
    output logic        IN_IDLE
);

    localparam int unsigned NCR_BITS = NCR_BYTES * 8;
    localparam int unsigned TX_BITS  = NCR_BITS + 8;
    localparam int unsigned CNT_W    = $clog2(ACMD41_BUSY_CNT + 1) + 1;

    localparam logic [6:0]       NCR_LAST    = 7'(NCR_BITS - 1);
    localparam logic [6:0]       TX_DONE     = 7'(TX_BITS);
    localparam logic [CNT_W-1:0] BUSY_RELOAD = CNT_W'(ACMD41_BUSY_CNT);

    typedef enum logic [1:0] {StHunt, StCmd, StNcr, StResp} state_e;

    state_e state_q, state_d;

    // Input synchronisers and SCLK edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall;

    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '1;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Datapath registers
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [46:0]        frame_q, frame_d;
    logic [TX_BITS-1:0] tx_q, tx_d;
    logic [6:0]         tx_cnt_q, tx_cnt_d;
    logic               miso_q, miso_d;
    logic               stb_q, stb_d;
    logic [5:0]         idx_q, idx_d;
    logic [31:0]        arg_q, arg_d;
    logic               cmd_app_q, cmd_app_d;
    logic               idle_q, idle_d;
    logic               app_q, app_d;
    logic [CNT_W-1:0]   busy_q, busy_d;
    logic [7:0]         r1;

    // Frame as it stands once the bit on this SCLK rise is shifted in
    logic [47:0] frame_full;
    logic [5:0]  rx_idx;
    logic        unused_bits;
    assign frame_full  = {frame_q, mosi_s};
    assign rx_idx      = frame_full[45:40];
    assign unused_bits = ^{frame_full[47], frame_full[7:0]};

`ifdef SD_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return crc;
    endfunction

    logic crc_bad;
    assign crc_bad = (crc7(frame_full[47:8]) != frame_full[7:1]);
`endif

    // State register
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = StHunt;
        end else begin
            unique case (state_q)
                StHunt: if (sclk_rise && !mosi_s) state_d = StCmd;
                StCmd: begin
                    if (sclk_rise) begin
                        // Transmission bit must be 1, otherwise drop the frame
                        if (bit_cnt_q == 6'd1 && !mosi_s) state_d = StHunt;
                        else if (bit_cnt_q == 6'd47)      state_d = StNcr;
                    end
                end
                StNcr:  if (sclk_fall && tx_cnt_q == NCR_LAST) state_d = StResp;
                // Leave on the rise where the host samples the last R1 bit
                StResp: if (sclk_rise && tx_cnt_q == TX_DONE) state_d = StHunt;
                default: state_d = StHunt;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        tx_d      = tx_q;
        tx_cnt_d  = tx_cnt_q;
        miso_d    = miso_q;
        stb_d     = 1'b0;
        idx_d     = idx_q;
        arg_d     = arg_q;
        cmd_app_d = cmd_app_q;
        idle_d    = idle_q;
        app_d     = app_q;
        busy_d    = busy_q;
        r1        = 8'h00;
        if (cs_s) begin
            miso_d = 1'b1;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (sclk_fall) miso_d = 1'b1;
                    if (sclk_rise && !mosi_s) begin
                        frame_d   = '0;
                        bit_cnt_d = 6'd1;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        frame_d   = frame_full[46:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd47) begin
                            stb_d     = 1'b1;
                            idx_d     = rx_idx;
                            arg_d     = frame_full[39:8];
                            cmd_app_d = app_q;
                            app_d     = 1'b0;
                            // State updates first so R1 reports post-command state
`ifdef SD_CRC_CHECK_EN
                            if (crc_bad) begin
                                r1 = {4'b0000, 1'b1, 2'b00, idle_q};
                            end else
`endif
                            if (rx_idx == 6'd0) begin
                                idle_d = 1'b1;
                                busy_d = BUSY_RELOAD;
                                r1     = 8'h01;
                            end else if (rx_idx == 6'd55) begin
                                app_d = 1'b1;
                                r1    = {7'b0, idle_q};
                            end else if (rx_idx == 6'd41 && app_q) begin
                                if (busy_q != '0) begin
                                    busy_d = busy_q - CNT_W'(1);
                                    r1     = 8'h01;
                                end else begin
                                    idle_d = 1'b0;
                                    r1     = 8'h00;
                                end
                            end else if ((rx_idx == 6'd17 || rx_idx == 6'd24 ||
                                          rx_idx == 6'd16) && !idle_q) begin
                                r1 = 8'h00;
                            end else begin
                                r1 = {5'b0, 1'b1, 1'b0, idle_q};
                            end
                            tx_d     = {{NCR_BITS{1'b1}}, r1};
                            tx_cnt_d = '0;
                        end
                    end
                end
                StNcr, StResp: begin
                    if (sclk_fall) begin
                        miso_d   = tx_q[TX_BITS-1];
                        tx_d     = {tx_q[TX_BITS-2:0], 1'b1};
                        tx_cnt_d = tx_cnt_q + 7'd1;
                    end
                end
                default: miso_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            bit_cnt_q <= '0;
            frame_q   <= '0;
            tx_q      <= '1;
            tx_cnt_q  <= '0;
            miso_q    <= 1'b1;
            stb_q     <= 1'b0;
            idx_q     <= '0;
            arg_q     <= '0;
            cmd_app_q <= 1'b0;
            idle_q    <= 1'b1;
            app_q     <= 1'b0;
            busy_q    <= BUSY_RELOAD;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            tx_q      <= tx_d;
            tx_cnt_q  <= tx_cnt_d;
            miso_q    <= miso_d;
            stb_q     <= stb_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            cmd_app_q <= cmd_app_d;
            idle_q    <= idle_d;
            app_q     <= app_d;
            busy_q    <= busy_d;
        end
    end

    assign MISO    = miso_q;
    assign CMD_STB = stb_q;
    assign CMD_IDX = idx_q;
    assign CMD_ARG = arg_q;
    assign CMD_APP = cmd_app_q;
    assign IN_IDLE = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: a host-side SPI driver feeds command frames and
// a reference model of the card init state predicts R1, CMD_* and IN_IDLE.
`timescale 1ns/1ps
module tb_sd_spi_responder;

    localparam int NCR_BYTES = 1;
    localparam int BUSY      = 2;
    localparam int HALF      = 80;

    logic        CLOCK50 = 1'b0;
    logic        RESET   = 1'b0;
    logic        SCLK    = 1'b0;
    logic        MOSI    = 1'b1;
    logic        CS      = 1'b1;
    logic        MISO;
    logic        CMD_STB;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    logic        CMD_APP;
    logic        IN_IDLE;

    always #10 CLOCK50 = ~CLOCK50;

    sd_spi_responder #(
        .NCR_BYTES      (NCR_BYTES),
        .ACMD41_BUSY_CNT(BUSY),
        .SYNC_STAGES    (2)
    ) dut (
        .CLOCK50(CLOCK50),
        .RESET  (RESET),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .CS     (CS),
        .MISO   (MISO),
        .CMD_STB(CMD_STB),
        .CMD_IDX(CMD_IDX),
        .CMD_ARG(CMD_ARG),
        .CMD_APP(CMD_APP),
        .IN_IDLE(IN_IDLE)
    );

    int checks  = 0;
    int errors  = 0;
    int stb_cnt = 0;

    // Each CLOCK50 cycle with CMD_STB high counts, so a stretched pulse shows up
    always @(negedge CLOCK50) if (CMD_STB === 1'b1) stb_cnt++;

    // Reference model of the card state
    int m_idle = 1;
    int m_app  = 0;
    int m_busy = BUSY;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC7 by polynomial long division of data * x^7 by x^7+x^3+1
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [46:0] rem;
        rem = {d, 7'b0};
        for (int i = 46; i >= 7; i--) if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        return rem[6:0];
    endfunction

    task automatic model_reset();
        m_idle = 1;
        m_app  = 0;
        m_busy = BUSY;
    endtask

    task automatic model_cmd(input int idx, input bit crc_ok, output logic [7:0] r1);
        int was_app;
        was_app = m_app;
        m_app   = 0;
        if (!crc_ok) begin
            r1 = 8'h08 + 8'(m_idle);
        end else if (idx == 0) begin
            m_idle = 1;
            m_busy = BUSY;
            r1     = 8'h01;
        end else if (idx == 55) begin
            m_app = 1;
            r1    = 8'(m_idle);
        end else if (idx == 41 && was_app == 1) begin
            if (m_busy > 0) begin
                m_busy--;
                r1 = 8'h01;
            end else begin
                m_idle = 0;
                r1     = 8'h00;
            end
        end else if ((idx == 17 || idx == 24 || idx == 16) && m_idle == 0) begin
            r1 = 8'h00;
        end else begin
            r1 = 8'h04 + 8'(m_idle);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        MOSI = b;
        #(HALF);
        SCLK = 1'b1;
        r    = MISO;
        #(HALF);
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit force_crc,
                          input logic [7:0] crc_in, input bit release_cs);
        logic [39:0] head;
        logic [7:0]  crc_byte, rx, exp_r1;
        logic [47:0] frame;
        logic        r;
        bit          crc_ok;
        int          exp_app, stb0;
        head     = {2'b01, idx, arg};
        crc_byte = force_crc ? crc_in : {crc7(head), 1'b1};
        frame    = {head, crc_byte};
        crc_ok   = 1'b1;
`ifdef SD_CRC_CHECK_EN
        crc_ok = (crc_byte[7:1] == crc7(head));
`endif
        exp_app = m_app;
        model_cmd(int'(idx), crc_ok, exp_r1);
        stb0 = stb_cnt;
        CS   = 1'b0;
        #(HALF);
        for (int i = 47; i >= 0; i--) spi_bit(frame[i], r);
        for (int n = 0; n < NCR_BYTES; n++) begin
            spi_byte(8'hFF, rx);
            check_eq($sformatf("cmd%0d_fill", idx), 32'(rx), 32'hFF);
        end
        spi_byte(8'hFF, rx);
        check_eq($sformatf("cmd%0d_r1", idx), 32'(rx), 32'(exp_r1));
        #(HALF);
        check_eq($sformatf("cmd%0d_stb", idx), 32'(stb_cnt - stb0), 32'd1);
        check_eq($sformatf("cmd%0d_idx", idx), 32'(CMD_IDX), 32'(idx));
        check_eq($sformatf("cmd%0d_arg", idx), CMD_ARG, arg);
        check_eq($sformatf("cmd%0d_app", idx), 32'(CMD_APP), 32'(exp_app));
        check_eq($sformatf("cmd%0d_idle", idx), 32'(IN_IDLE), 32'(m_idle));
        if (release_cs) begin
            CS = 1'b1;
            #(200);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_miso"}, 32'(MISO), 32'd1);
        check_eq({pfx, "_stb"}, 32'(CMD_STB), 32'd0);
        check_eq({pfx, "_idx"}, 32'(CMD_IDX), 32'd0);
        check_eq({pfx, "_arg"}, CMD_ARG, 32'd0);
        check_eq({pfx, "_app"}, 32'(CMD_APP), 32'd0);
        check_eq({pfx, "_idle"}, 32'(IN_IDLE), 32'd1);
    endtask

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] frame;
        logic [7:0]  rx;
        logic        r;
        logic [2:0]  bits;
        int          stb0, pick;
        logic [7:0]  exp_r1;

        // Host activity is offset by 3 ns from CLOCK50 edges
        #53;
        check_reset_outputs("reset");
        #50;
        RESET = 1'b1;
        #200;

        // CMD0
        do_cmd(6'd0, 32'h0, 1'b1, 8'h95, 1'b1);

        // CMD55 + ACMD41, three times
        for (int k = 0; k < 3; k++) begin
            do_cmd(6'd55, 32'h0, 1'b1, 8'h65, 1'b0);
            do_cmd(6'd41, 32'h40000000, 1'b1, 8'h77, 1'b1);
        end

        do_cmd(6'd17, 32'h00001000, 1'b0, 8'h00, 1'b0);
        do_cmd(6'd8, 32'h000001AA, 1'b0, 8'h00, 1'b1);

        // Partial CMD0: 20 bits then CS released
        frame = 48'h400000000095;
        stb0  = stb_cnt;
        CS    = 1'b0;
        #(HALF);
        for (int i = 47; i >= 28; i--) spi_bit(frame[i], r);
        CS = 1'b1;
        #(400);
        check_eq("partial_stb", 32'(stb_cnt - stb0), 32'd0);
        check_eq("partial_idle", 32'(IN_IDLE), 32'(m_idle));
        do_cmd(6'd0, 32'h0, 1'b1, 8'h95, 1'b1);

        // Frame with transmission bit 0 is dropped silently
        stb0 = stb_cnt;
        CS   = 1'b0;
        #(HALF);
        spi_byte(8'h3F, rx);
        for (int n = 0; n < 6 + NCR_BYTES; n++) begin
            spi_byte(8'hFF, rx);
            check_eq("badtx_miso", 32'(rx), 32'hFF);
        end
        check_eq("badtx_stb", 32'(stb_cnt - stb0), 32'd0);
        CS = 1'b1;
        #(200);

        // Re-init, then reset in the middle of a CMD17 R1 (0x00)
        do_cmd(6'd0, 32'h0, 1'b1, 8'h95, 1'b0);
        for (int k = 0; k < BUSY + 1; k++) begin
            do_cmd(6'd55, 32'h0, 1'b0, 8'h00, 1'b0);
            do_cmd(6'd41, 32'h40000000, 1'b0, 8'h00, 1'b0);
        end
        frame = {2'b01, 6'd17, 32'h00000200, crc7({2'b01, 6'd17, 32'h00000200}), 1'b1};
        CS    = 1'b0;
        #(HALF);
        for (int i = 47; i >= 0; i--) spi_bit(frame[i], r);
        for (int n = 0; n < NCR_BYTES; n++) spi_byte(8'hFF, rx);
        for (int i = 2; i >= 0; i--) begin
            spi_bit(1'b1, r);
            bits[i] = r;
        end
        check_eq("resp_bits", 32'(bits), 32'd0);
        #(40);
        RESET = 1'b0;
        #(5);
        check_reset_outputs("midresp");
        #(5);
        CS = 1'b1;
        #(100);
        RESET = 1'b1;
        model_reset();
        #(100);
        do_cmd(6'd0, 32'h0, 1'b1, 8'h95, 1'b1);

        // CRC handling on CMD0
        do_cmd(6'd0, 32'h0, 1'b1, 8'h01, 1'b1);
        do_cmd(6'd0, 32'h0, 1'b1, 8'h95, 1'b1);

        // Randomized command stream
        for (int k = 0; k < 40; k++) begin
            pick = int'($urandom_range(0, 7));
            unique case (pick)
                0: do_cmd(6'd0, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                1: begin
                    do_cmd(6'd55, $urandom, 1'b0, 8'h00, 1'b0);
                    do_cmd(6'd41, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                end
                2: do_cmd(6'd41, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                3: do_cmd(6'd17, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                4: do_cmd(6'd24, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                5: do_cmd(6'd16, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                6: do_cmd(6'd55, $urandom, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                default: do_cmd(6'($urandom_range(0, 63)), $urandom, 1'b0, 8'h00,
                                1'($urandom_range(0, 1)));
            endcase
        end
        exp_r1 = 8'h00;
        CS = 1'b1;
        #(200);
        check_eq("final_idle", 32'(IN_IDLE), 32'(m_idle) | 32'(exp_r1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD card responder: the card end of the link driven by our SD card driver.
- Receives 48-bit command frames on MOSI/SCLK/CS and returns an R1 response on MISO after NCR_BYTES filler bytes.
- Tracks card init state (idle, app-command prefix, ACMD41 busy count) and reports each decoded command to local logic.
- Used as the card model in driver benches and as an FPGA-side card emulator.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes between the command end bit and the R1 byte (range 1..8).
- ACMD41_BUSY_CNT, 2, number of ACMD41 commands answered 0x01 before the first 0x00.
- SYNC_STAGES, 2, synchroniser depth on SCLK/MOSI/CS (minimum 2).

Ports:
- CLOCK50  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from host, mode 0, at most CLOCK50/8.
- MOSI  in  1  host-to-card data.
- CS  in  1  chip select, active-low.
- MISO  out  1  card-to-host data, idles high.
- CMD_STB  out  1  one CLOCK50 pulse per accepted command frame.
- CMD_IDX  out  6  index of the last accepted command.
- CMD_ARG  out  32  argument of the last accepted command.
- CMD_APP  out  1  last accepted command was prefixed by CMD55.
- IN_IDLE  out  1  card idle-state flag (R1 bit0).

Behaviour:
- Reset (RESET=0, asynchronous): MISO=1, CMD_STB=0, CMD_IDX=0, CMD_ARG=0, CMD_APP=0, IN_IDLE=1, app flag=0, ACMD41 counter=ACMD41_BUSY_CNT, FSM=HUNT.
- Sampling: SCLK, MOSI and CS pass through SYNC_STAGES flops.
  - Synchronised SCLK rising edge samples MOSI.
  - Synchronised SCLK falling edge shifts the next MISO bit, MSB first.
- CS high (synchronised) at any time: FSM->HUNT, MISO=1, and the partial frame is discarded with no CMD_STB. The app flag is kept.
- FSM:
  - HUNT: MISO=1. The first sampled MOSI=0 while CS is low is the start bit; bit count=1 -> CMD.
  - CMD: shift 48 bits total.
    - If bit 46 (transmission bit) is not 1, return to HUNT silently.
    - After bit 48, latch index[45:40] and arg[39:8], then -> NCR.
  - NCR: output NCR_BYTES×8 ones, then build R1 -> RESP.
  - RESP: output 8 R1 bits, then -> HUNT.
- CMD_STB pulses on the CLOCK50 cycle after the 48th bit is sampled; CMD_IDX, CMD_ARG and CMD_APP update on the same cycle.
- R1 encoding: bit0=idle, bit2=illegal command, bit3=CRC error, all other bits 0.
- Command decode, in priority order:
  - CMD0: IN_IDLE:=1, app flag:=0, ACMD41 counter reloads; R1=0x01.
  - CMD55: app flag:=1; R1={IN_IDLE}.
  - CMD41 with app flag set: if counter>0, decrement and R1=0x01; if counter=0, IN_IDLE:=0 and R1=0x00.
  - CMD17, CMD24, CMD16 (not idle): R1=0x00.
  - Any other command, including CMD8 (v1 card behaviour) and CMD17/24/16 while idle: R1=0x04|IN_IDLE.
- App flag clears after any command other than CMD55.
- State changes caused by a command take effect before its R1 is built, so the R1 reflects post-command state (e.g. the final ACMD41 returns 0x00).
- A new start bit received during NCR/RESP is ignored; the host must clock out the response first.

Optional Feature:
- SD_CRC_CHECK_EN defined:
  - CRC7 (poly x^7+x^3+1) is computed over the first 40 bits and compared with bits[7:1].
  - On mismatch: R1=0x08|IN_IDLE, no state change, app flag cleared, CMD_STB still pulses.
- Undefined: CRC bits are ignored and no CRC logic is synthesised.

Test Plan:
- CMD0 frame 40 00 00 00 00 95, CS low -> MISO bytes FF then 01; CMD_STB=1 once, CMD_IDX=0, IN_IDLE=1.
- CMD55 (77 00 00 00 00 65) then ACMD41 (69 40 00 00 00 77), repeated 3×, ACMD41_BUSY_CNT=2 -> ACMD41 R1 sequence 01, 01, 00; IN_IDLE=0 after the third; CMD_APP=1 on each ACMD41.
- CMD17 arg 0x00001000 after init -> R1=00, CMD_IDX=17, CMD_ARG=0x00001000; CMD8 -> R1=04.
- CS released after 20 bits of a CMD0 frame, then a full CMD0 -> no CMD_STB for the partial frame; the full frame returns FF 01.
- RESET asserted during RESP -> MISO=1 immediately and all outputs at reset values; the next CMD0 answers normally.
- With SD_CRC_CHECK_EN, CMD0 sent with CRC byte 0x01 -> R1=09; the same frame with 0x95 -> R1=01.
